// File: rtl/reg_port_pkg.sv
// Shared state encoding and PC-related constants for the register-port controller.
package reg_port_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_ISSUE    = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_COMMIT   = 3'd4
   } state_e;

   localparam logic [3:0]  PC_SELECT      = 4'd15;
   localparam logic [31:0] PC_INC         = 32'd4;
   localparam logic [31:0] PC_READ_OFFSET = 32'd8;

endpackage

// File: rtl/pc_operand_adj.sv
// Substitutes the pipelined PC view (PC + 8) when an operand index selects the PC.
module pc_operand_adj
   import reg_port_pkg::*;
(
   input  logic [3:0]  idx_i,
   input  logic [31:0] data_i,
   input  logic [31:0] pc_data_i,
   output logic [31:0] operand_o
);

   assign operand_o = (idx_i == PC_SELECT) ? (pc_data_i + PC_READ_OFFSET) : data_i;

endmodule

// File: rtl/reg_port_ctrl.sv
// Register-port controller: reads operands, hands them to the ALU, collects the
// result and commits it plus the PC advance to the register bank.
//
// state     | meaning
// ST_IDLE   | ready for a new request
// ST_READ   | selects driven with latched Rn/Rm, operands captured at cycle end
// ST_ISSUE  | operands offered to ALU until taken
// ST_WAIT_RES | waiting for ALU result (write-back requests only)
// ST_COMMIT | one-cycle bank write of PC+4 and, with write-back, Rd
module reg_port_ctrl
   import reg_port_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_rn_i,
   input  logic [3:0]  req_rm_i,
   input  logic [3:0]  req_rd_i,
   input  logic        req_wb_i,
   output logic [3:0]  rb_read_a_select_o,
   output logic [3:0]  rb_read_b_select_o,
   input  logic [31:0] rb_read_a_data_i,
   input  logic [31:0] rb_read_b_data_i,
   input  logic [31:0] rb_read_pc_data_i,
   output logic [3:0]  rb_write_select_o,
   output logic        rb_write_en_o,
   output logic [31:0] rb_write_data_o,
   output logic        rb_write_pc_en_o,
   output logic [31:0] rb_write_pc_data_o,
   output logic        op_valid_o,
   input  logic        op_ready_i,
   output logic [31:0] op_a_o,
   output logic [31:0] op_b_o,
   input  logic        res_valid_i,
   input  logic [31:0] res_data_i,
   output logic        res_ready_o
);

   state_e      state_q, state_d;
   logic [3:0]  rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
   logic        wb_q, wb_d;
   logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
   logic [31:0] adj_a, adj_b;

   pc_operand_adj u_adj_a (
      .idx_i     (rn_q),
      .data_i    (rb_read_a_data_i),
      .pc_data_i (rb_read_pc_data_i),
      .operand_o (adj_a)
   );

   pc_operand_adj u_adj_b (
      .idx_i     (rm_q),
      .data_i    (rb_read_b_data_i),
      .pc_data_i (rb_read_pc_data_i),
      .operand_o (adj_b)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         rn_q    <= '0;
         rm_q    <= '0;
         rd_q    <= '0;
         wb_q    <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         rn_q    <= rn_d;
         rm_q    <= rm_d;
         rd_q    <= rd_d;
         wb_q    <= wb_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      rn_d               = rn_q;
      rm_d               = rm_q;
      rd_d               = rd_q;
      wb_d               = wb_q;
      op_a_d             = op_a_q;
      op_b_d             = op_b_q;
      res_d              = res_q;
      req_ready_o        = 1'b0;
      rb_read_a_select_o = '0;
      rb_read_b_select_o = '0;
      rb_write_select_o  = '0;
      rb_write_en_o      = 1'b0;
      rb_write_data_o    = '0;
      rb_write_pc_en_o   = 1'b0;
      rb_write_pc_data_o = '0;
      op_valid_o         = 1'b0;
      res_ready_o        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Gate with reset so ready stays low for the whole reset pulse.
            req_ready_o = rst_n_i;
            if (req_valid_i) begin
               rn_d    = req_rn_i;
               rm_d    = req_rm_i;
               rd_d    = req_rd_i;
               wb_d    = req_wb_i;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            rb_read_a_select_o = rn_q;
            rb_read_b_select_o = rm_q;
            op_a_d             = adj_a;
            op_b_d             = adj_b;
            state_d            = ST_ISSUE;
         end
         ST_ISSUE: begin
            op_valid_o = 1'b1;
            if (op_ready_i) begin
               state_d = wb_q ? ST_WAIT_RES : ST_COMMIT;
            end
         end
         ST_WAIT_RES: begin
            res_ready_o = 1'b1;
            if (res_valid_i) begin
               res_d   = res_data_i;
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            // The bank drops the PC port itself when Rd is the PC.
            rb_write_pc_en_o   = 1'b1;
            rb_write_pc_data_o = rb_read_pc_data_i + PC_INC;
            if (wb_q) begin
               rb_write_en_o     = 1'b1;
               rb_write_select_o = rd_q;
               rb_write_data_o   = res_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign op_a_o = op_a_q;
   assign op_b_o = op_b_q;

endmodule

// File: tb/tb_reg_port_ctrl.sv
// Directed bench for reg_port_ctrl with a transaction-level bank model and a per-cycle checker.
module tb_reg_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_wb;
   logic [3:0]  req_rn, req_rm, req_rd;
   logic [3:0]  sel_a, sel_b, wsel;
   logic [31:0] rd_a, rd_b, rd_pc;
   logic        wen, wpc_en;
   logic [31:0] wdata, wpc_data;
   logic        op_valid, op_ready;
   logic [31:0] op_a, op_b;
   logic        res_valid, res_ready;
   logic [31:0] res_data;

   logic [31:0] bank [16];
   logic [31:0] model_bank [16];
   logic        preload_en;
   logic [3:0]  preload_idx;
   logic [31:0] preload_val;

   logic [31:0] exp_a, exp_b, exp_res, exp_pcw;
   logic [3:0]  exp_rd;
   logic        exp_wb;
   logic [31:0] seen_a, seen_b;
   int          commits_seen = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   reg_port_ctrl dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_rn_i           (req_rn),
      .req_rm_i           (req_rm),
      .req_rd_i           (req_rd),
      .req_wb_i           (req_wb),
      .rb_read_a_select_o (sel_a),
      .rb_read_b_select_o (sel_b),
      .rb_read_a_data_i   (rd_a),
      .rb_read_b_data_i   (rd_b),
      .rb_read_pc_data_i  (rd_pc),
      .rb_write_select_o  (wsel),
      .rb_write_en_o      (wen),
      .rb_write_data_o    (wdata),
      .rb_write_pc_en_o   (wpc_en),
      .rb_write_pc_data_o (wpc_data),
      .op_valid_o         (op_valid),
      .op_ready_i         (op_ready),
      .op_a_o             (op_a),
      .op_b_o             (op_b),
      .res_valid_i        (res_valid),
      .res_data_i         (res_data),
      .res_ready_o        (res_ready)
   );

   // Register bank: PC lives at index 15; a general write to 15 overrides the PC port.
   assign rd_a  = bank[sel_a];
   assign rd_b  = bank[sel_b];
   assign rd_pc = bank[15];

   always @(posedge clk) begin
      if (preload_en) begin
         bank[preload_idx] <= preload_val;
      end else begin
         if (wen) bank[wsel] <= wdata;
         if (wpc_en && !(wen && wsel == 4'd15)) bank[15] <= wpc_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_operand(input logic [3:0] idx);
      return (idx == 4'd15) ? model_bank[15] + 32'd8 : model_bank[idx];
   endfunction

   // Per-cycle compare against the current transaction's expectations.
   always begin
      @(posedge clk);
      #1;
      if (op_valid) begin
         chk("op_a", op_a, exp_a);
         chk("op_b", op_b, exp_b);
      end
      if (wen || wpc_en) begin
         commits_seen++;
         chk("commit_pc_en", {31'd0, wpc_en}, 32'd1);
         chk("commit_pc_data", wpc_data, exp_pcw);
         chk("commit_wen", {31'd0, wen}, {31'd0, exp_wb});
         if (exp_wb) begin
            chk("commit_wsel", {28'd0, wsel}, {28'd0, exp_rd});
            chk("commit_wdata", wdata, exp_res);
         end
      end else begin
         chk("idle_wsel", {28'd0, wsel}, 32'd0);
         chk("idle_wdata", wdata, 32'd0);
         chk("idle_pc_data", wpc_data, 32'd0);
      end
      if (req_ready) begin
         chk("ready_exclusive", {31'd0, op_valid | res_ready | wen | wpc_en}, 32'd0);
      end
   end

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge clk);
      preload_en  = 1'b1;
      preload_idx = idx;
      preload_val = val;
      @(negedge clk);
      preload_en  = 1'b0;
      model_bank[idx] = val;
   endtask

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_strobes", {30'd0, wen, wpc_en}, 32'd0);
      chk("rst_handshakes", {30'd0, op_valid, res_ready}, 32'd0);
      chk("rst_selects", {20'd0, sel_a, sel_b, wsel}, 32'd0);
      chk("rst_wdata", wdata | wpc_data, 32'd0);
      chk("rst_ops", op_a | op_b, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
   endtask

   // abort: 0 none, 1 reset in WAIT_RES, 2 reset in COMMIT
   task automatic run_txn(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                          input logic wb, input logic [31:0] res, input int res_dly,
                          input int op_dly, input int abort, input logic junk);
      int n0;
      int t;
      exp_a   = model_operand(rn);
      exp_b   = model_operand(rm);
      exp_wb  = wb;
      exp_rd  = rd;
      exp_res = res;
      exp_pcw = model_bank[15] + 32'd4;
      n0      = commits_seen;
      wait_ready();
      req_valid = 1'b1;
      req_rn = rn; req_rm = rm; req_rd = rd; req_wb = wb;
      if (junk) begin
         res_valid = 1'b1;
         res_data  = 32'h0BAD0BAD;
      end
      @(negedge clk);
      req_valid = 1'b0;
      t = 0;
      while (!op_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("op_valid_timeout", {31'd0, op_valid}, 32'd1);
      seen_a = op_a;
      seen_b = op_b;
      for (int i = 0; i < op_dly; i++) begin
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      if (wb) begin
         for (int i = 0; i < res_dly; i++) begin
            chk("res_ready_held", {31'd0, res_ready}, 32'd1);
            @(negedge clk);
         end
         if (abort == 1) begin
            chk("abort_in_wait", {31'd0, res_ready}, 32'd1);
            do_reset();
         end else begin
            res_valid = 1'b1;
            res_data  = res;
            @(negedge clk);
            res_valid = 1'b0;
         end
      end
      if (abort == 2) begin
         chk("abort_in_commit", {31'd0, wpc_en}, 32'd1);
         do_reset();
      end
      res_valid = 1'b0;
      if (abort == 0) begin
         wait_ready();
         if (wb) model_bank[rd] = res;
         if (!(wb && rd == 4'd15)) model_bank[15] = exp_pcw;
         chk("commit_count", commits_seen, n0 + 1);
      end
      chk("bank_rd", bank[rd], model_bank[rd]);
      chk("bank_pc", bank[15], model_bank[15]);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_rn = '0; req_rm = '0; req_rd = '0; req_wb = 1'b0;
      op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
      preload_en = 1'b0; preload_idx = '0; preload_val = '0;
      exp_a = '0; exp_b = '0; exp_res = '0; exp_pcw = '0; exp_rd = '0; exp_wb = 1'b0;
      seen_a = '0; seen_b = '0;
      #2;
      chk_reset_outputs();
      for (int i = 0; i < 16; i++) begin
         preload(4'(i), (i == 1) ? 32'd5 : (i == 2) ? 32'd7 :
                        (i == 15) ? 32'h100 : 32'h1000 + 32'(i));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", {31'd0, req_ready}, 32'd1);

      run_txn(4'd1, 4'd2, 4'd0, 1'b0, 32'd0, 0, 0, 0, 1'b0);
      chk("lit_op_a_r1", seen_a, 32'd5);
      chk("lit_op_b_r2", seen_b, 32'd7);
      chk("lit_pc_104", bank[15], 32'h104);

      preload(4'd15, 32'h200);
      run_txn(4'd15, 4'd2, 4'd0, 1'b0, 32'd0, 0, 0, 0, 1'b0);
      chk("lit_op_a_pc", seen_a, 32'h208);

      run_txn(4'd1, 4'd2, 4'd3, 1'b1, 32'hDEADBEEF, 3, 0, 0, 1'b0);
      chk("lit_r3", bank[3], 32'hDEADBEEF);
      chk("lit_pc_208", bank[15], 32'h208);

      run_txn(4'd1, 4'd3, 4'd15, 1'b1, 32'h400, 1, 0, 0, 1'b0);
      chk("lit_pc_from_result", bank[15], 32'h400);

      preload(4'd15, 32'hFFFFFFFC);
      run_txn(4'd15, 4'd15, 4'd6, 1'b0, 32'd0, 0, 5, 0, 1'b1);
      chk("lit_op_a_wrap", seen_a, 32'h4);
      chk("lit_pc_wrap", bank[15], 32'h0);

      run_txn(4'd5, 4'd15, 4'd7, 1'b1, 32'h12345678, 0, 2, 0, 1'b0);
      chk("lit_op_a_r5", seen_a, 32'h1005);
      chk("lit_op_b_pc", seen_b, 32'h8);

      run_txn(4'd1, 4'd2, 4'd4, 1'b1, 32'hCAFE0001, 2, 0, 1, 1'b0);
      run_txn(4'd1, 4'd2, 4'd4, 1'b1, 32'hCAFE0002, 0, 1, 2, 1'b0);
      chk("lit_r4_untouched", bank[4], 32'h1004);
      chk("lit_pc_untouched", bank[15], 32'h4);

      run_txn(4'd3, 4'd7, 4'd4, 1'b1, 32'h55, 0, 0, 0, 1'b0);
      chk("lit_r4_recovered", bank[4], 32'h55);
      chk("lit_pc_recovered", bank[15], 32'h8);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/reg_port_ctrl.md
REG_PORT_CTRL -- requirements
Module: reg_port_ctrl

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RST_N  input  1  reset, asynchronous, active-low.
REQ-003 REQ_VALID  input  1  decode presents a register-access request.
REQ-004 REQ_READY  output  1  controller accepts a request.
REQ-005 REQ_RN, REQ_RM, REQ_RD  input  4 each  operand A index, operand B index, destination index.
REQ-006 REQ_WB  input  1  request writes a result to Rd.
REQ-007 RB_READ_A_SELECT, RB_READ_B_SELECT  output  4 each  bank read-port selects.
REQ-008 RB_READ_A_DATA, RB_READ_B_DATA, RB_READ_PC_DATA  input  32 each  bank read data, combinational from the selects.
REQ-009 RB_WRITE_SELECT  output  4  bank write index.
REQ-010 RB_WRITE_EN  output  1  bank general write strobe.
REQ-011 RB_WRITE_DATA  output  32  bank general write data.
REQ-012 RB_WRITE_PC_EN  output  1  bank PC write strobe.
REQ-013 RB_WRITE_PC_DATA  output  32  bank PC write data.
REQ-014 OP_VALID  output  1  operands valid toward ALU/shifter.
REQ-015 OP_READY  input  1  ALU/shifter takes operands.
REQ-016 OP_A, OP_B  output  32 each  captured operands.
REQ-017 RES_VALID  input  1  ALU result present.
REQ-018 RES_DATA  input  32  ALU result.
REQ-019 RES_READY  output  1  controller takes result.

Function
REQ-020 The FSM SHALL have exactly five states: IDLE, READ, ISSUE, WAIT_RES, COMMIT; one request in flight at a time.
REQ-021 REQ_READY SHALL be 1 only in IDLE; on REQ_VALID&REQ_READY, latch RN/RM/RD/WB and go to READ.
REQ-022 In READ, selects SHALL equal the latched RN/RM; at the end of READ, OP_A/OP_B SHALL capture the read data; next state ISSUE.
REQ-023 When a latched operand index is 15, the captured value SHALL be RB_READ_PC_DATA+8, modulo 2^32.
REQ-024 In ISSUE, OP_VALID SHALL be 1 and OP_A/OP_B stable until OP_VALID&OP_READY; then go to WAIT_RES if WB=1, else COMMIT.
REQ-025 RES_READY SHALL be 1 only in WAIT_RES; on RES_VALID&RES_READY, latch RES_DATA and go to COMMIT; RES_VALID in any other state SHALL be ignored.
REQ-026 COMMIT SHALL last one cycle with RB_WRITE_PC_EN=1 and RB_WRITE_PC_DATA=RB_READ_PC_DATA+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-027 In COMMIT with WB=1, RB_WRITE_EN=1, RB_WRITE_SELECT=RD, RB_WRITE_DATA=latched result; with WB=0, RB_WRITE_EN=0.
REQ-028 With RD=15 and WB=1, the result SHALL land in PC and the PC+4 write SHALL be discarded, because the bank suppresses the PC port when the write index is 15.
REQ-029 Outside COMMIT, RB_WRITE_EN=0, RB_WRITE_PC_EN=0, RB_WRITE_SELECT=0, RB_WRITE_DATA=0, RB_WRITE_PC_DATA=0.
REQ-030 COMMIT SHALL return to IDLE, so at most one request is accepted every four cycles (five with WB).

Reset
REQ-031 RST_N low SHALL immediately force IDLE and zero all latched fields and all outputs except REQ_READY, which stays 0 while RST_N is low.
REQ-032 Reset asserted mid-operation SHALL abandon the request with no bank write, including during COMMIT.
REQ-033 REQ_READY SHALL assert in the first cycle after RST_N deasserts.

Structure
REQ-034 Package reg_port_pkg SHALL hold the state encoding and the constants PC_SELECT=15, PC_INC=4 and PC_READ_OFFSET=8.
REQ-035 One sub-module, pc_operand_adj, SHALL implement the index-15 operand substitution of REQ-023, instantiated once per read port.

Verification
REQ-036 RN=1, RM=2, bank R1=5, R2=7, PC=0x100, WB=0, OP_READY=1 -> OP_A=5 and OP_B=7 in ISSUE; COMMIT writes PC 0x104 with RB_WRITE_EN=0.
REQ-037 RN=15, PC=0x200 -> OP_A=0x208.
REQ-038 WB=1, RD=3, RES_DATA=0xDEADBEEF delayed 3 cycles -> RES_READY held for those cycles; COMMIT writes R3=0xDEADBEEF and PC+4.
REQ-039 WB=1, RD=15, RES_DATA=0x400 -> the bank PC ends at 0x400, not the old PC+4.
REQ-040 OP_READY held 0 for 5 cycles -> OP_A/OP_B stable, no bank write, REQ_READY=0; and PC=0xFFFFFFFC -> the PC write is 0x00000000.
REQ-041 RST_N pulsed low in WAIT_RES and in COMMIT -> no write strobe, outputs 0, REQ_READY=1 in the cycle after release.
